// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and op-class helpers.
package mdu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10,
        MFHI  = 4'd11,
        MFLO  = 4'd12
    } mduOpE;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateE;

    function automatic logic is_multicycle(input logic [OP_W-1:0] o);
        return o inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] o);
        return o inside {DIV, DIVU};
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator: products, accumulates and divides,
// including the divide-by-zero hold and signed-overflow cases.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] shadow
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [W2-1:0]    acc;
    logic [W2-1:0]    prodS;
    logic [W2-1:0]    prodU;
    logic [WIDTH-1:0] safeB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] magQ;
    logic [WIDTH-1:0] magR;
    logic [WIDTH-1:0] quoS;
    logic [WIDTH-1:0] remS;
    logic             divZero;
    logic             divOvf;

    always_comb begin
        acc   = {hi, lo};
        // low 2*WIDTH bits of the sign-extended product equal the signed product
        prodS = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prodU = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

        divZero = (src_b == '0);
        divOvf  = (src_a == MIN_NEG) && (src_b == '1);
        safeB   = divZero ? WIDTH'(1) : src_b;

        // signed divide on magnitudes, then fix signs (truncate toward zero)
        magA = src_a[WIDTH-1] ? -src_a : src_a;
        magB = safeB[WIDTH-1] ? -safeB : safeB;
        magQ = magA / magB;
        magR = magA % magB;
        quoS = (src_a[WIDTH-1] ^ safeB[WIDTH-1]) ? -magQ : magQ;
        remS = src_a[WIDTH-1] ? -magR : magR;

        shadow = acc;
        case (op)
            MULT:    shadow = prodS;
            MULTU:   shadow = prodU;
            MADD:    shadow = acc + prodS;
            MADDU:   shadow = acc + prodU;
            MSUB:    shadow = acc - prodS;
            MSUBU:   shadow = acc - prodU;
            DIV: begin
                if (divZero)     shadow = acc;
                else if (divOvf) shadow = {{WIDTH{1'b0}}, MIN_NEG};
                else             shadow = {remS, quoS};
            end
            DIVU: begin
                if (divZero) shadow = acc;
                else         shadow = {src_a % safeB, src_a / safeB};
            end
            default: shadow = acc;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// E-stage multiply/divide unit: owns HI/LO, runs multicycle ops for a fixed
// per-class latency and gates issue and MTHI/MTLO with the exception request.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    output logic              busy,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    stateE              state;
    stateE              stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] shadow;
    logic [2*WIDTH-1:0] calcOut;
    logic               startAccept;
    logic               commit;

    mdu_calc #(.WIDTH(WIDTH)) uCalc (
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi     (hi),
        .lo     (lo),
        .shadow (calcOut)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // busy is combinational so a dependent MFHI/MFLO stalls in the issue cycle
    always_comb begin
        stateNext   = state;
        startAccept = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !req && is_multicycle(op)) begin
                    startAccept = 1'b1;
                    stateNext   = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        busy = startAccept || (state == RUN);
    end

    // req never aborts a running op; it only blocks new issue and MTHI/MTLO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            shadow <= '0;
        end else begin
            if (startAccept) begin
                shadow <= calcOut;
                cnt    <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (commit) begin
                {hi, lo} <= shadow;
            end else if (!req && !busy) begin
                if (op == MTHI) hi <= src_a;
                if (op == MTLO) lo <= src_a;
            end
        end
    end

    always_comb begin
        result = '0;
        if (op == MFHI)      result = hi;
        else if (op == MFLO) result = lo;
    end

    assign hi_o = hi;
    assign lo_o = lo;

    noStartWhileRun: assert property (@(posedge clk) disable iff (!reset)
        !(state == RUN && start));

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter against an arithmetic HI/LO model.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hiO;
    logic [31:0] loO;

    logic        start2;
    logic        req2;
    logic [3:0]  op2;
    logic [15:0] srcA2;
    logic [15:0] srcB2;
    logic        busy2;
    logic [15:0] result2;
    logic [15:0] hiO2;
    logic [15:0] loO2;

    int          total;
    int          bad;
    logic [31:0] mHi;
    logic [31:0] mLo;

    mdu_iter dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .src_a(srcA), .src_b(srcB), .busy(busy), .result(result),
        .hi_o(hiO), .lo_o(loO)
    );

    mdu_iter #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(2), .CNT_W(2)) dut16 (
        .clk(clk), .reset(reset), .req(req2), .start(start2), .op(op2),
        .src_a(srcA2), .src_b(srcB2), .busy(busy2), .result(result2),
        .hi_o(hiO2), .lo_o(loO2)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {HI,LO} after an op, straight from the arithmetic definitions
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] acc;
        logic [63:0] ps;
        logic [63:0] pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {h, l};
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        case (o)
            MULT:  return ps;
            MULTU: return pu;
            MADD:  return acc + ps;
            MADDU: return acc + pu;
            MSUB:  return acc - ps;
            MSUBU: return acc - pu;
            DIV: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    task automatic runMc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          n;
        n = is_div(o) ? 10 : 5;
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b; req = 1'b0;
        #1;
        checkVal($sformatf("busy_accept op%0d", o), 64'(busy), 64'(1));
        exp = model(o, a, b, mHi, mLo);
        @(negedge clk);
        start = 1'b0; op = NOP;
        for (int k = 0; k < n; k++) begin
            checkVal($sformatf("busy_run op%0d k%0d", o, k), 64'(busy), 64'(1));
            if (k == n - 1) checkVal("hilo_hold", {hiO, loO}, {mHi, mLo});
            @(negedge clk);
        end
        {mHi, mLo} = exp;
        checkVal($sformatf("busy_done op%0d", o), 64'(busy), 64'(0));
        checkVal($sformatf("hilo op%0d a=%h b=%h", o, a, b), {hiO, loO}, exp);
    endtask

    task automatic moveTo(input logic [3:0] o, input logic [31:0] v, input logic r);
        @(negedge clk);
        start = 1'b0; op = o; srcA = v; req = r;
        #1;
        checkVal("mt_busy", 64'(busy), 64'(0));
        @(negedge clk);
        op = NOP; req = 1'b0;
        if (!r) begin
            if (o == MTHI) mHi = v;
            else           mLo = v;
        end
        checkVal($sformatf("mt op%0d req%0d", o, r), {hiO, loO}, {mHi, mLo});
    endtask

    task automatic blockedIssue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b; req = 1'b1;
        #1;
        checkVal("blocked_busy_now", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0; op = NOP; req = 1'b0;
        #1;
        checkVal("blocked_busy_next", 64'(busy), 64'(0));
        checkVal("blocked_hilo", {hiO, loO}, {mHi, mLo});
    endtask

    task automatic readBack();
        @(negedge clk);
        op = MFHI;
        #1 checkVal("mfhi", 64'(result), 64'(mHi));
        op = MFLO;
        #1 checkVal("mflo", 64'(result), 64'(mLo));
        op = NOP;
        #1 checkVal("result_nop", 64'(result), 64'(0));
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; req = 1'b0; start = 1'b0; op = NOP;
        srcA = '0; srcB = '0;
        start2 = 1'b0; req2 = 1'b0; op2 = NOP; srcA2 = '0; srcB2 = '0;
        total = 0; bad = 0; mHi = '0; mLo = '0;

        #1;
        checkVal("rst_busy", 64'(busy), 64'(0));
        checkVal("rst_result", 64'(result), 64'(0));
        checkVal("rst_hi", 64'(hiO), 64'(0));
        checkVal("rst_lo", 64'(loO), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        runMc(MULT, 32'hFFFFFFFE, 32'd3);
        checkVal("mult_hi", 64'(hiO), 64'hFFFFFFFF);
        checkVal("mult_lo", 64'(loO), 64'hFFFFFFFA);
        runMc(MULTU, 32'hFFFFFFFE, 32'd3);
        checkVal("multu_hi", 64'(hiO), 64'h2);
        checkVal("multu_lo", 64'(loO), 64'hFFFFFFFA);
        runMc(DIV, 32'hFFFFFFF9, 32'd2);
        checkVal("div_lo", 64'(loO), 64'hFFFFFFFD);
        checkVal("div_hi", 64'(hiO), 64'hFFFFFFFF);
        runMc(DIVU, 32'd7, 32'd0);
        checkVal("divz_lo", 64'(loO), 64'hFFFFFFFD);
        checkVal("divz_hi", 64'(hiO), 64'hFFFFFFFF);

        moveTo(MTHI, 32'd1, 1'b0);
        moveTo(MTLO, 32'hFFFFFFFF, 1'b0);
        runMc(MADDU, 32'd1, 32'd1);
        checkVal("maddu_hi", 64'(hiO), 64'h2);
        checkVal("maddu_lo", 64'(loO), 64'h0);
        runMc(MSUB, 32'd1, 32'd1);
        checkVal("msub_hi", 64'(hiO), 64'h1);
        checkVal("msub_lo", 64'(loO), 64'hFFFFFFFF);

        blockedIssue(MULT, 32'd5, 32'd5);
        moveTo(MTLO, 32'h123, 1'b1);
        checkVal("mtlo_req_lo", 64'(loO), 64'hFFFFFFFF);

        // req raised mid-flight must not abort the older op
        @(negedge clk);
        start = 1'b1; op = MULT; srcA = 32'd5; srcB = 32'd5;
        @(negedge clk);
        start = 1'b0; op = NOP;
        @(negedge clk);
        req = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("reqrun_hold", {hiO, loO}, {32'h1, 32'hFFFFFFFF});
        checkVal("reqrun_busy", 64'(busy), 64'(1));
        @(negedge clk);
        checkVal("reqrun_lo", 64'(loO), 64'd25);
        checkVal("reqrun_hi", 64'(hiO), 64'd0);
        checkVal("reqrun_done", 64'(busy), 64'(0));
        req = 1'b0;
        mHi = 32'd0; mLo = 32'd25;

        runMc(DIV, 32'h80000000, 32'hFFFFFFFF);
        checkVal("ovf_lo", 64'(loO), 64'h80000000);
        checkVal("ovf_hi", 64'(hiO), 64'h0);
        readBack();

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 4'($urandom_range(0, 12));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 20)) - 32'd10; end
                default: ;
            endcase
            if (is_multicycle(o)) begin
                if ($urandom_range(0, 3) == 0) blockedIssue(o, a, b);
                else                           runMc(o, a, b);
            end else if (o == MTHI || o == MTLO) begin
                moveTo(o, a, $urandom_range(0, 3) == 0);
            end else begin
                readBack();
            end
        end

        // asynchronous reset in the middle of a run
        moveTo(MTHI, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        start = 1'b1; op = MULT; srcA = 32'd3; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0; op = NOP;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("midrst_busy", 64'(busy), 64'(0));
        checkVal("midrst_hi", 64'(hiO), 64'(0));
        checkVal("midrst_lo", 64'(loO), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        mHi = '0; mLo = '0;
        repeat (6) @(negedge clk);
        checkVal("midrst_stay", {hiO, loO}, 64'(0));

        // 16-bit, single-cycle multiply instance
        @(negedge clk);
        start2 = 1'b1; op2 = MULT; srcA2 = 16'hFFFE; srcB2 = 16'd3;
        #1 checkVal("w16_busy_accept", 64'(busy2), 64'(1));
        @(negedge clk);
        start2 = 1'b0; op2 = NOP;
        checkVal("w16_busy_run", 64'(busy2), 64'(1));
        checkVal("w16_lo_hold", 64'(loO2), 64'(0));
        @(negedge clk);
        checkVal("w16_busy_done", 64'(busy2), 64'(0));
        checkVal("w16_hi", 64'(hiO2), 64'hFFFF);
        checkVal("w16_lo", 64'(loO2), 64'hFFFA);
        op2 = MFLO;
        #1 checkVal("w16_mflo", 64'(result2), 64'hFFFA);
        @(negedge clk);
        start2 = 1'b1; op2 = DIV; srcA2 = 16'hFFF9; srcB2 = 16'd2;
        @(negedge clk);
        start2 = 1'b0; op2 = NOP;
        @(negedge clk);
        checkVal("w16_div_hold", 64'(loO2), 64'hFFFA);
        @(negedge clk);
        checkVal("w16_div_lo", 64'(loO2), 64'hFFFD);
        checkVal("w16_div_hi", 64'(hiO2), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
